alu_pipe: RTL and testbench

//  Parametrised, 2-stage pipelined ALU: successor of the 4-bit add/sub/compare/and mux.

---
 rtl/alu_pipe_pkg.sv | 19 +
 rtl/alu_pipe_core.sv | 45 ++++
 rtl/alu_pipe.sv | 79 +++++++
 tb/tb_alu_pipe.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the pipelined ALU: opcode encodings and compare-result bit positions.
package alu_pipe_pkg;

   typedef enum logic [2:0] {
      OP_ADD     = 3'b000,
      OP_SUB     = 3'b001,
      OP_CMP     = 3'b010,
      OP_AND     = 3'b011,
      OP_OR      = 3'b100,
      OP_XOR     = 3'b101,
      OP_ACC_ADD = 3'b110,
      OP_ACC_CLR = 3'b111
   } op_e;

   localparam int unsigned CMP_LT = 0;
   localparam int unsigned CMP_EQ = 1;
   localparam int unsigned CMP_GT = 2;

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath: {op, a, b, acc} -> {y, acc_next, acc_we}.
module alu_pipe_core
   import alu_pipe_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  op_e              op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] acc,
   output logic [WIDTH:0]   y,
   output logic [WIDTH-1:0] acc_next,
   output logic             acc_we
);

   always_comb begin
      y        = '0;
      acc_next = acc;
      acc_we   = 1'b0;
      case (op)
         OP_ADD: y = {1'b0, a} + {1'b0, b};
         // borrow shows up in the MSB because the subtraction wraps at WIDTH+1 bits
         OP_SUB: y = {1'b0, a} - {1'b0, b};
         OP_CMP: begin
            y[CMP_GT] = (a > b);
            y[CMP_EQ] = (a == b);
            y[CMP_LT] = (a < b);
         end
         OP_AND: y = {1'b0, a & b};
         OP_OR:  y = {1'b0, a | b};
         OP_XOR: y = {1'b0, a ^ b};
         OP_ACC_ADD: begin
            y        = {1'b0, acc} + {1'b0, a};
            acc_next = y[WIDTH-1:0];
            acc_we   = 1'b1;
         end
         OP_ACC_CLR: begin
            y        = {1'b0, acc};
            acc_next = '0;
            acc_we   = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes; owns the stage registers and accumulator.
module alu_pipe
   import alu_pipe_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   Y,
   output logic             flag_z
);

   logic             s1_valid;
   op_e              s1_op;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [WIDTH-1:0] acc;
   logic [WIDTH:0]   res;
   logic [WIDTH-1:0] acc_next;
   logic             acc_we;
   logic             adv1;
   logic             adv2;

   assign adv2     = enable & s1_valid & (~out_valid | out_ready);
   assign adv1     = enable & (~s1_valid | adv2);
   assign in_ready = adv1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_op    <= OP_ADD;
         s1_a     <= '0;
         s1_b     <= '0;
      end else if (adv1) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_op <= op_e'(op);
            s1_a  <= a;
            s1_b  <= b;
         end
      end
   end

   alu_pipe_core #(.WIDTH(WIDTH)) u_core (
      .op       (s1_op),
      .a        (s1_a),
      .b        (s1_b),
      .acc      (acc),
      .y        (res),
      .acc_next (acc_next),
      .acc_we   (acc_we)
   );

   // acc moves with the op into S2, so in-order ACC ops see each other's result without forwarding
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         Y         <= '0;
         flag_z    <= 1'b1;
         acc       <= '0;
      end else if (adv2) begin
         out_valid <= 1'b1;
         Y         <= res;
         flag_z    <= (res == '0);
         if (acc_we) acc <= acc_next;
      end else if (enable & out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed beats push expected results, a monitor pops on each transfer.
module tb_alu_pipe;

   localparam int unsigned W = 4;

   logic         clk;
   logic         rst;
   logic         enable;
   logic         in_valid;
   logic         in_ready;
   logic [2:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W:0]   Y;
   logic         flag_z;

   int n_checks = 0;
   int n_fail   = 0;
   logic [W:0] sb[$];

   alu_pipe #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Y         (Y),
      .flag_z    (flag_z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && enable && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_output", 32'(Y), 32'h1ff);
         end else begin
            logic [W:0] e;
            e = sb.pop_front();
            check("Y", 32'(Y), 32'(e));
            check("flag_z", 32'(flag_z), 32'(e == '0));
         end
      end
   end

   // Presents one beat and waits (bounded) for acceptance; returns at posedge+1 with in_valid still high.
   task automatic send(input logic [2:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                       input logic [W:0] ey);
      int unsigned budget;
      op = o; a = xa; b = xb; in_valid = 1'b1;
      budget = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         budget++;
         if (budget > 50) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            return;
         end
      end
      sb.push_back(ey);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int unsigned budget;
      in_valid = 1'b0;
      budget = 0;
      while (sb.size() != 0 && budget < 50) begin
         @(posedge clk);
         #1;
         budget++;
      end
      check("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   logic [2:0]   bp_op [4];
   logic [W-1:0] bp_a  [4];
   logic [W:0]   bp_y  [4];

   initial begin
      int unsigned idx;
      int unsigned accepted;
      logic        acc_now;

      rst = 1'b1; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      op = 3'b000; a = '0; b = '0;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_Y", 32'(Y), 32'd0);
      check("rst_flag_z", 32'(flag_z), 32'd1);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Basic opcodes at full rate
      send(3'b000, 4'hF, 4'h1, 5'h10);
      send(3'b001, 4'h3, 4'h5, 5'h1E);
      send(3'b001, 4'h5, 4'h5, 5'h00);
      send(3'b010, 4'h7, 4'h7, 5'b00010);
      send(3'b010, 4'h8, 4'h2, 5'b00100);
      send(3'b010, 4'h2, 4'h8, 5'b00001);
      send(3'b011, 4'hC, 4'hA, 5'h08);
      send(3'b100, 4'hC, 4'hA, 5'h0E);
      send(3'b101, 4'hC, 4'hA, 5'h06);
      // Accumulator sequence, back to back
      send(3'b111, 4'h0, 4'h0, 5'h00);
      send(3'b110, 4'h9, 4'h3, 5'h09);
      send(3'b110, 4'h9, 4'h3, 5'h12);
      send(3'b111, 4'h0, 4'h0, 5'h02);
      send(3'b111, 4'h0, 4'h0, 5'h00);
      drain();

      // Backpressure: only two beats fit while the consumer stalls
      bp_op[0] = 3'b000; bp_a[0] = 4'h1; bp_y[0] = 5'h02;
      bp_op[1] = 3'b000; bp_a[1] = 4'h2; bp_y[1] = 5'h04;
      bp_op[2] = 3'b000; bp_a[2] = 4'h3; bp_y[2] = 5'h06;
      bp_op[3] = 3'b000; bp_a[3] = 4'h4; bp_y[3] = 5'h08;
      out_ready = 1'b0;
      idx = 0; accepted = 0;
      op = bp_op[0]; a = bp_a[0]; b = bp_a[0]; in_valid = 1'b1;
      repeat (6) begin
         @(negedge clk);
         acc_now = in_ready;
         if (acc_now) begin
            sb.push_back(bp_y[idx]);
            accepted++;
         end
         @(posedge clk);
         #1;
         if (acc_now) begin
            idx++;
            op = bp_op[idx]; a = bp_a[idx]; b = bp_a[idx];
         end
      end
      @(negedge clk);
      check("bp_accepted", 32'(accepted), 32'd2);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_Y_held", 32'(Y), 32'h02);
      @(posedge clk);
      #1 out_ready = 1'b1;
      send(bp_op[2], bp_a[2], bp_a[2], bp_y[2]);
      send(bp_op[3], bp_a[3], bp_a[3], bp_y[3]);
      drain();

      // Freeze with one beat in S2 and one in S1
      send(3'b110, 4'h5, 4'h0, 5'h05);
      send(3'b110, 4'h5, 4'h0, 5'h0A);
      in_valid = 1'b0;
      enable = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("frz_in_ready", 32'(in_ready), 32'd0);
         check("frz_out_valid", 32'(out_valid), 32'd1);
         check("frz_Y", 32'(Y), 32'h05);
         check("frz_flag_z", 32'(flag_z), 32'd0);
      end
      @(posedge clk);
      #1 enable = 1'b1;
      send(3'b111, 4'h0, 4'h0, 5'h0A);
      drain();

      // Reset with two beats in flight
      out_ready = 1'b0;
      send(3'b110, 4'h3, 4'h0, 5'h03);
      send(3'b000, 4'h2, 4'h2, 5'h04);
      in_valid = 1'b0;
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_Y", 32'(Y), 32'd0);
      check("mid_rst_flag_z", 32'(flag_z), 32'd1);
      sb.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      out_ready = 1'b1;
      send(3'b111, 4'h0, 4'h0, 5'h00);
      send(3'b000, 4'h7, 4'h8, 5'h0F);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
